// File: rtl/spi_flash_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_ctrl
// Purpose  : SPI mode-0 master for the configuration flash, driven from the
//            J1 IO bus. Contains one MSB-first byte engine with a programmable
//            SCLK half-period divider and a software chip select. An optional
//            read-command sequencer issues a 0x03 header and then streams
//            flash bytes one DATA read at a time.
// Config   : define SPI_FLASH_READSEQ_EN to compile in the read sequencer.
// Ports    : clk, resetq (async active-low)
//            sel, io_rd, io_wr, reg_idx[1:0], io_dout[15:0] - IO bus side
//            rdata[15:0] - register read data (0 when not selected)
//            busy        - byte transfer / header in progress
//            sclk, mosi, ss_n, miso - SPI pins
// Registers: 0 DATA  W: start byte  R: {8'd0, rx_byte}
//            1 CTRL  W: [0] cs, [1] clear ovr, [15:8] div
//                    R: {div, 4'd0, seq_active, ovr, cs, busy}
//            2 SEQ   W: start read at {io_dout, 8'h00} (sequencer builds only)
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_ctrl #(
  parameter int DIV_W     = 8,
  parameter int RESET_DIV = 3
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        sel,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [1:0]  reg_idx,
  input  logic [15:0] io_dout,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  output logic        ss_n,
  input  logic        miso
);

  typedef enum logic {ENG_IDLE, ENG_SHIFT} eng_state_t;

  eng_state_t       eng_q, eng_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [3:0]       phase_q;
  logic [7:0]       sr_q;
  logic [7:0]       rx_q;
  logic             ovr_q;

  logic wr_data, wr_ctrl, wr_seq, rd_data;
  assign wr_data = sel && io_wr && (reg_idx == 2'd0);
  assign wr_ctrl = sel && io_wr && (reg_idx == 2'd1);
  assign wr_seq  = sel && io_wr && (reg_idx == 2'd2);
  assign rd_data = sel && io_rd && (reg_idx == 2'd0);

  // A phase boundary is the last clk of a phase; the byte ends on the
  // boundary of phase 15.
  logic boundary, last;
  assign boundary = (eng_q == ENG_SHIFT) && (cnt_q == '0);
  assign last     = boundary && (phase_q == 4'd15);
  assign busy     = (eng_q == ENG_SHIFT);

  logic       seq_load;
  logic [7:0] seq_byte;
  logic       seq_cs;
  logic       seq_active;
  logic       seq_reject;

`ifdef SPI_FLASH_READSEQ_EN
  typedef enum logic [2:0] {
    SEQ_IDLE, SEQ_HDR0, SEQ_HDR1, SEQ_HDR2, SEQ_HDR3, SEQ_STREAM
  } seq_state_t;

  seq_state_t  seq_q, seq_d;
  logic [15:0] addr_q;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      seq_q  <= SEQ_IDLE;
      addr_q <= '0;
    end else begin
      seq_q <= seq_d;
      if (wr_seq && !busy) addr_q <= io_dout;
    end
  end

  // Each HDRn state names the header byte currently on the wire; the next
  // byte is chained on the completion edge so the engine never idles.
  always_comb begin
    seq_d    = seq_q;
    seq_load = 1'b0;
    seq_byte = 8'h00;
    seq_cs   = 1'b0;
    if (wr_ctrl && !io_dout[0]) begin
      seq_d = SEQ_IDLE;
    end else if (wr_seq && !busy) begin
      seq_d    = SEQ_HDR0;
      seq_load = 1'b1;
      seq_byte = 8'h03;
      seq_cs   = 1'b1;
    end else begin
      case (seq_q)
        SEQ_HDR0: if (last) begin seq_d = SEQ_HDR1;   seq_load = 1'b1; seq_byte = addr_q[15:8]; end
        SEQ_HDR1: if (last) begin seq_d = SEQ_HDR2;   seq_load = 1'b1; seq_byte = addr_q[7:0];  end
        SEQ_HDR2: if (last) begin seq_d = SEQ_HDR3;   seq_load = 1'b1; end
        SEQ_HDR3: if (last) begin seq_d = SEQ_STREAM; seq_load = 1'b1; end
        SEQ_STREAM: if (rd_data && !busy) seq_load = 1'b1;
        default: seq_d = SEQ_IDLE;
      endcase
    end
  end

  assign seq_active = (seq_q == SEQ_STREAM);
  assign seq_reject = wr_seq && busy;
`else
  assign seq_load   = 1'b0;
  assign seq_byte   = 8'h00;
  assign seq_cs     = 1'b0;
  assign seq_active = 1'b0;
  assign seq_reject = 1'b0;
  logic unused_seq;
  assign unused_seq = ^{io_rd, wr_seq, rd_data};
`endif

  // Byte launch: sequencer requests and software DATA writes never coincide
  // (chaining only happens while busy, and starts need distinct strobes).
  logic       load;
  logic [7:0] load_byte;
  always_comb begin
    load      = 1'b0;
    load_byte = io_dout[7:0];
    if (seq_load) begin
      load      = 1'b1;
      load_byte = seq_byte;
    end else if (wr_data && !busy) begin
      load = 1'b1;
    end
  end

  always_comb begin
    eng_d = eng_q;
    if (load)      eng_d = ENG_SHIFT;
    else if (last) eng_d = ENG_IDLE;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) eng_q <= ENG_IDLE;
    else         eng_q <= eng_d;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      cnt_q   <= '0;
      phase_q <= 4'd0;
      sr_q    <= 8'h00;
      rx_q    <= 8'h00;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      if (last) rx_q <= sr_q;
      if (load) begin
        sr_q    <= load_byte;
        mosi    <= load_byte[7];
        phase_q <= 4'd0;
        cnt_q   <= div_q;
        sclk    <= 1'b0;
      end else if (last) begin
        sclk <= 1'b0;
      end else if (boundary) begin
        phase_q <= phase_q + 4'd1;
        cnt_q   <= div_q;
        if (!phase_q[0]) begin
          // Entering a high phase: capture MISO as SCLK rises.
          sclk <= 1'b1;
          sr_q <= {sr_q[6:0], miso};
        end else begin
          // Entering a low phase: present the next bit (already shifted up).
          sclk <= 1'b0;
          mosi <= sr_q[7];
        end
      end else if (eng_q == ENG_SHIFT) begin
        cnt_q <= cnt_q - DIV_W'(1);
      end
    end
  end

  // Chip select is held as ss_n directly so the pin is a plain flop output.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      ss_n  <= 1'b1;
      div_q <= DIV_W'(RESET_DIV);
      ovr_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ss_n  <= ~io_dout[0];
        div_q <= DIV_W'(io_dout[15:8]);
      end else if (seq_cs) begin
        ss_n <= 1'b0;
      end
      if (wr_ctrl && io_dout[1])              ovr_q <= 1'b0;
      else if ((wr_data && busy) || seq_reject) ovr_q <= 1'b1;
    end
  end

  logic [7:0] div_field;
  assign div_field = 8'(div_q);

  always_comb begin
    rdata = 16'h0000;
    if (sel) begin
      case (reg_idx)
        2'd0:    rdata = {8'h00, rx_q};
        2'd1:    rdata = {div_field, 4'h0, seq_active, ovr_q, ~ss_n, busy};
        default: rdata = 16'h0000;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_ctrl
// Purpose  : Directed self-checking bench for spi_flash_ctrl: reset state,
//            loopback, divider, overrun, read sequencer (when
//            SPI_FLASH_READSEQ_EN is defined) and reset mid-byte.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_ctrl;

  logic        clk     = 1'b0;
  logic        resetq  = 1'b0;
  logic        sel     = 1'b0;
  logic        io_rd   = 1'b0;
  logic        io_wr   = 1'b0;
  logic [1:0]  reg_idx = 2'd0;
  logic [15:0] io_dout = 16'h0000;
  logic [15:0] rdata;
  logic        busy, sclk, mosi, ss_n, miso;

  int checks   = 0;
  int failures = 0;

  // Slave model: counts SCLK rising edges, captures MOSI, serves MISO either
  // as a loopback or from a table of response bytes (MSB first).
  int          rises    = 0;
  int          base     = 0;
  logic [63:0] mosi_cap = 64'h0;
  logic        loopback = 1'b1;
  logic [7:0]  rsp [0:7];
  logic [31:0] rel;

  spi_flash_ctrl #(.DIV_W(8), .RESET_DIV(3)) dut (
    .clk     (clk),
    .resetq  (resetq),
    .sel     (sel),
    .io_rd   (io_rd),
    .io_wr   (io_wr),
    .reg_idx (reg_idx),
    .io_dout (io_dout),
    .rdata   (rdata),
    .busy    (busy),
    .sclk    (sclk),
    .mosi    (mosi),
    .ss_n    (ss_n),
    .miso    (miso)
  );

  always #5 clk = ~clk;

  always @(posedge sclk) begin
    rises    <= rises + 1;
    mosi_cap <= {mosi_cap[62:0], mosi};
  end

  assign rel  = 32'(rises - base);
  assign miso = loopback ? mosi : rsp[rel[5:3]][3'd7 - rel[2:0]];

`ifdef SPI_FLASH_READSEQ_EN
  int   ss_viol = 0;
  logic seq_mon = 1'b0;
  always @(negedge clk) if (seq_mon && ss_n) ss_viol <= ss_viol + 1;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic io_write(input logic [1:0] idx, input logic [15:0] d);
    @(negedge clk);
    sel = 1'b1; io_wr = 1'b1; reg_idx = idx; io_dout = d;
    @(negedge clk);
    sel = 1'b0; io_wr = 1'b0;
  endtask

  task automatic io_read(input logic [1:0] idx, output logic [15:0] d);
    @(negedge clk);
    sel = 1'b1; io_rd = 1'b1; reg_idx = idx;
    #1 d = rdata;
    @(negedge clk);
    sel = 1'b0; io_rd = 1'b0;
  endtask

  // Counts busy cycles from the current negedge and records SCLK per cycle.
  task automatic measure_busy(output int n, output logic [63:0] tr);
    n  = 0;
    tr = 64'h0;
    while (busy && n < 300) begin
      if (n < 64) tr[n] = sclk;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] rd;
    logic [63:0] tr;
    int          n;
    int          r0;

    for (int i = 0; i < 8; i++) rsp[i] = 8'hFF;

    // ---------------- reset ----------------
    resetq = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ss_n", 64'(ss_n), 64'd1);
    check("rst_sclk", 64'(sclk), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mosi", 64'(mosi), 64'd0);
    resetq = 1'b1;
    io_read(2'd1, rd);
    check("rst_ctrl", 64'(rd), 64'h0300);
    io_read(2'd0, rd);
    check("rst_data", 64'(rd), 64'h0000);

    // ---------------- loopback, div=0 ----------------
    loopback = 1'b1;
    io_write(2'd1, 16'h0001);
    check("lb_ss_n", 64'(ss_n), 64'd0);
    r0 = rises;
    io_write(2'd0, 16'h00A5);
    check("lb_mosi_first", 64'(mosi), 64'd1);
    measure_busy(n, tr);
    check("lb_busy_cycles", 64'(n), 64'd16);
    check("lb_sclk_trace", tr, 64'h0000_0000_0000_AAAA);
    check("lb_rises", 64'(rises - r0), 64'd8);
    check("lb_mosi_byte", 64'(mosi_cap[7:0]), 64'hA5);
    io_read(2'd0, rd);
    check("lb_rx", 64'(rd), 64'h00A5);

    // ---------------- divider, div=3, slave returns 0xC3 ----------------
    loopback = 1'b0;
    rsp[0]   = 8'hC3;
    io_write(2'd1, 16'h0301);
    base = rises;
    r0   = rises;
    io_write(2'd0, 16'h003C);
    measure_busy(n, tr);
    check("div_busy_cycles", 64'(n), 64'd64);
    check("div_sclk_trace", tr, 64'hF0F0_F0F0_F0F0_F0F0);
    check("div_rises", 64'(rises - r0), 64'd8);
    check("div_mosi_byte", 64'(mosi_cap[7:0]), 64'h3C);
    io_read(2'd0, rd);
    check("div_rx", 64'(rd), 64'h00C3);

    // ---------------- overrun, div=1 ----------------
    loopback = 1'b1;
    io_write(2'd1, 16'h0101);
    r0 = rises;
    io_write(2'd0, 16'h0011);
    io_write(2'd0, 16'h0022);
    measure_busy(n, tr);
    check("ovr_busy_remaining", 64'(n), 64'd30);
    check("ovr_rises", 64'(rises - r0), 64'd8);
    check("ovr_mosi_byte", 64'(mosi_cap[7:0]), 64'h11);
    io_read(2'd1, rd);
    check("ovr_ctrl_set", 64'(rd), 64'h0106);
    io_read(2'd0, rd);
    check("ovr_rx", 64'(rd), 64'h0011);
    io_write(2'd1, 16'h0103);
    io_read(2'd1, rd);
    check("ovr_ctrl_clear", 64'(rd), 64'h0102);

`ifdef SPI_FLASH_READSEQ_EN
    // ---------------- read sequencer, div=0 ----------------
    io_write(2'd1, 16'h0000);
    loopback = 1'b0;
    for (int i = 0; i < 8; i++) rsp[i] = 8'hFF;
    rsp[4] = 8'hDE;
    rsp[5] = 8'hAD;
    base = rises;
    io_write(2'd2, 16'h1234);
    seq_mon = 1'b1;
    measure_busy(n, tr);
    check("seq_busy_cycles", 64'(n), 64'd80);
    check("seq_mosi_header", 64'(mosi_cap[39:0]), 64'h03_12_34_00_00);
    io_read(2'd1, rd);
    check("seq_ctrl_stream", 64'(rd), 64'h000A);
    io_read(2'd0, rd);
    check("seq_rd0", 64'(rd), 64'h00DE);
    measure_busy(n, tr);
    check("seq_next_busy", 64'(n), 64'd16);
    io_read(2'd0, rd);
    check("seq_rd1", 64'(rd), 64'h00AD);
    measure_busy(n, tr);
    seq_mon = 1'b0;
    check("seq_ss_n_low", 64'(ss_viol), 64'd0);
    io_write(2'd1, 16'h0000);
    io_read(2'd1, rd);
    check("seq_end_ctrl", 64'(rd), 64'h0000);
    check("seq_end_ss_n", 64'(ss_n), 64'd1);
`else
    // ---------------- SEQ writes ignored without the sequencer ----------------
    io_write(2'd2, 16'h1234);
    check("noseq_busy", 64'(busy), 64'd0);
    io_read(2'd1, rd);
    check("noseq_ctrl", 64'(rd), 64'h0102);
`endif

    // ---------------- reset mid-byte, div=1 ----------------
    loopback = 1'b1;
    io_write(2'd1, 16'h0101);
    io_write(2'd0, 16'h005A);
    repeat (14) @(negedge clk);
    check("mid_phase7_sclk", 64'(sclk), 64'd1);
    check("mid_phase7_busy", 64'(busy), 64'd1);
    #2 resetq = 1'b0;
    #1;
    check("mid_rst_ss_n", 64'(ss_n), 64'd1);
    check("mid_rst_sclk", 64'(sclk), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_mosi", 64'(mosi), 64'd0);
    @(negedge clk);
    resetq = 1'b1;
    io_read(2'd1, rd);
    check("mid_ctrl_after", 64'(rd), 64'h0300);
    io_read(2'd0, rd);
    check("mid_rx_cleared", 64'(rd), 64'h0000);
    io_write(2'd1, 16'h0301);
    r0 = rises;
    io_write(2'd0, 16'h0096);
    measure_busy(n, tr);
    check("mid_new_busy", 64'(n), 64'd64);
    check("mid_new_rises", 64'(rises - r0), 64'd8);
    io_read(2'd0, rd);
    check("mid_new_rx", 64'(rd), 64'h0096);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_flash_ctrl.md
# spi_flash_ctrl

Hardware SPI master that sequences the configuration-flash SPI pins (SCLK/MOSI/SS/MISO) on behalf of the J1 core and replaces per-bit software toggling through the IO bus. It sits on the J1 IO bus next to the ticks, terminal and PORTA registers. The top level decodes one IO address bit into `sel` and passes `io_addr[1:0]` as the register index. One mode-0 byte engine with a programmable clock divider and software chip-select is always present. An optional hardware read-command sequencer streams flash bytes one DATA read at a time.

## Interface
- `DIV_W`, default 8: width of the SCLK half-period divider field.
- `RESET_DIV`, default 3: divider value after reset; SCLK half-period = `RESET_DIV`+1 clk cycles.

Ports:
- `clk`  in  1  system clock, 24 MHz core clock domain.
- `resetq`  in  1  reset, asynchronous active-low.
- `sel`  in  1  block selected by the IO decode.
- `io_rd`  in  1  J1 IO read strobe.
- `io_wr`  in  1  J1 IO write strobe.
- `reg_idx`  in  2  register index: 0 DATA, 1 CTRL, 2 SEQ.
- `io_dout`  in  16  write data from the J1.
- `rdata`  out  16  read data, combinational from `reg_idx`, zero when `sel`=0.
- `busy`  out  1  a byte transfer or header sequence is in progress.
- `sclk`  out  1  SPI clock, idles low.
- `mosi`  out  1  SPI data out.
- `ss_n`  out  1  flash chip select, active low.
- `miso`  in  1  SPI data in.

## Operation
- **Registers**
  - **DATA (0), write:** starts a byte transfer of `io_dout[7:0]` when the block is idle. A write while busy is dropped and sets `ovr`.
  - **DATA (0), read:** returns `{8'd0, rx_byte}`.
  - **CTRL (1), write:** bit0 = `cs`, which drives `ss_n` = ~`cs`; bits[15:8] = `div`. Bit1 = 1 clears `ovr`.
  - **CTRL (1), read:** `{div, 4'd0, seq_active, ovr, cs, busy}`.
- **Byte engine:** SPI mode 0, MSB first.
  - The engine shifts over 16 phases, and each phase lasts `div`+1 clk cycles.
  - Even phases: `sclk`=0, with `mosi` driven with the current bit.
  - Odd phases: `sclk`=1. On entry to an odd phase, `miso` is sampled into bit 0 of the shift register.
  - After phase 15 completes, `sclk` returns to 0, `rx_byte` loads from the shift register and `busy` drops.
- **Engine states:** IDLE, SHIFT. The divider counter reloads at every phase boundary.
- **CTRL writes while busy:**
  - A change to `div` takes effect at the next phase boundary.
  - Clearing `cs` deasserts `ss_n` immediately, and the engine finishes the byte anyway. Software must not do this.
- **Simultaneous events:** `io_wr` and `io_rd` in the same cycle do not occur on the J1 and need not be handled. A DATA write in the completion cycle (the cycle `busy` falls) is treated as busy and dropped.

## Timing
- **Reset values:** `sclk`=0, `mosi`=0, `ss_n`=1, `busy`=0, `rx_byte`=0, `ovr`=0, `div`=`RESET_DIV`, sequencer IDLE.
- **Byte transfer:** a DATA write sampled at clk edge T gives `busy`=1 from T+1. `busy` stays high for exactly 16·(`div`+1) cycles, and `rx_byte` is valid in the cycle `busy` falls.
- **First data bit:** `mosi` carries bit 7 from T+1, at least `div`+1 cycles before the first rising edge of `sclk`.
- **Output glitches:** `sclk`, `mosi` and `ss_n` are registered and glitch-free.
- **Reset mid-transfer:** asserting `resetq` mid-transfer returns all outputs to their reset values asynchronously. No partial byte is kept.

## Configuration
- **`SPI_FLASH_READSEQ_EN` defined:** the sequencer is compiled in.
  - **Start:** a SEQ write while idle latches A = {`io_dout`, 8'h00}. The flash read address is therefore 256-byte aligned.
  - **Header:** the sequencer sets `cs`=1 and runs the engine back-to-back on 0x03, A[23:16], A[15:8] and 0x00. There is no idle cycle between header bytes, and `busy` stays high across all four.
  - **Stream:** the sequencer then enters STREAM (`seq_active`=1) and issues one 0x00 byte. Each later DATA read while not busy triggers the next 0x00 byte in the cycle after the read.
  - **End:** a CTRL write with `cs`=0 ends STREAM.
  - **States:** IDLE, HDR0–HDR3, STREAM.
  - **Rejected SEQ write:** a SEQ write while busy sets `ovr` and is ignored.
- **`SPI_FLASH_READSEQ_EN` undefined:** SEQ writes are ignored, `seq_active` reads 0, and no sequencer logic is synthesised.

## Test plan
- **Reset:** hold `resetq`=0, release. Expect `ss_n`=1, `sclk`=0, `busy`=0, CTRL read = 0x0300.
- **Loopback:** `div`=0, `cs`=1, `miso` tied to `mosi`, DATA write 0xA5. Expect `busy` high exactly 16 cycles, 8 `sclk` rising edges, DATA read 0x00A5.
- **Divider:** `div`=3, DATA write 0x3C with a `miso` model returning 0xC3. Expect `busy` for 64 cycles, `sclk` high/low 4 cycles each, DATA read 0x00C3.
- **Overrun:** DATA write 0x11, then DATA write 0x22 two cycles later. Expect the 0x11 waveform only and CTRL bit2 (`ovr`) = 1. CTRL write with bit1=1 clears `ovr`.
- **Sequencer (macro defined):** SEQ write 0x1234 against a flash model holding 0xDE 0xAD at 0x123400. Expect MOSI bytes 03 12 34 00, `ss_n` low throughout, first DATA read 0xDE and next 0xAD. CTRL `cs`=0 ends STREAM.
- **Reset mid-byte:** assert `resetq` low at phase 7 of a transfer. Expect immediate `ss_n`=1, `sclk`=0, `busy`=0. After release, a new transfer completes normally.
